// File: rtl/bitstream_unpacker.sv
// rtl/bitstream_unpacker.sv - entropy_encoder bundle receiver: descriptor FIFO plus serial byte expander.
// Optional per-frame byte counter output enabled by BITSTREAM_UNPACK_COUNT_EN.
module bitstream_unpacker #(
  parameter int BYTE_WIDTH      = 8,
  parameter int FIFO_DEPTH_LOG2 = 3
`ifdef BITSTREAM_UNPACK_COUNT_EN
  ,
  parameter int COUNT_WIDTH     = 24
`endif
) (
  input  logic                  top_clk,
  input  logic                  top_reset_n,
  input  logic [BYTE_WIDTH-1:0] in_bit_1,
  input  logic [BYTE_WIDTH-1:0] in_bit_2,
  input  logic [BYTE_WIDTH-1:0] in_bit_3,
  input  logic [BYTE_WIDTH-1:0] in_bit_4,
  input  logic [BYTE_WIDTH-1:0] in_bit_5,
  input  logic [2:0]            in_flag_bitstream,
  input  logic                  in_flag_last,
  output logic [BYTE_WIDTH-1:0] out_byte,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_frame_done,
  output logic                  out_overflow,
  output logic                  out_bad_flag,
  output logic                  out_fifo_empty
`ifdef BITSTREAM_UNPACK_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] out_frame_bytes
`endif
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int DW    = 5 * BYTE_WIDTH + 4;
  localparam logic [FIFO_DEPTH_LOG2:0] PTR_ONE  = 1;
  localparam logic [BYTE_WIDTH-1:0]    BYTE_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_B1,
    S_RUN,
    S_B4,
    S_B5,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                     r_last_d;
  logic                     r_overflow;
  logic                     r_bad_flag;
  logic [DW-1:0]            r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2:0] r_rd_ptr;

  logic [BYTE_WIDTH-1:0] r_b1, r_b2, r_b3, r_b4, r_b5;
  logic [2:0]            r_flag;
  logic                  r_last;
  logic [1:0]            r_idx;
  logic [BYTE_WIDTH-1:0] r_cnt;

  logic                  w_last_rise;
  logic                  w_is_bad;
  logic                  w_data_push;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_full;
  logic                  w_empty;
  logic [2:0]            w_desc_flag;
  logic [DW-1:0]         w_desc;
  logic [DW-1:0]         w_head;
  logic [2:0]            w_head_flag;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_hs;
  logic [BYTE_WIDTH-1:0] w_byte;
  logic                  w_done;
  logic                  w_idx_inc;
  logic                  w_cnt_load;
  logic                  w_cnt_dec;

  // Capture side: the last level is held by the encoder, so only its rising edge is an event.
  assign w_last_rise = in_flag_last & ~r_last_d;
  assign w_is_bad    = (in_flag_bitstream == 3'd4);
  assign w_data_push = (in_flag_bitstream != 3'd0) && !w_is_bad;
  assign w_push_req  = w_data_push | w_last_rise;
  assign w_desc_flag = w_data_push ? in_flag_bitstream : 3'd0;
  assign w_desc      = {w_last_rise, w_desc_flag, in_bit_5, in_bit_4, in_bit_3, in_bit_2, in_bit_1};

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FIFO_DEPTH_LOG2] != r_rd_ptr[FIFO_DEPTH_LOG2]) &&
                   (r_wr_ptr[FIFO_DEPTH_LOG2-1:0] == r_rd_ptr[FIFO_DEPTH_LOG2-1:0]);
  // Fullness is judged before this cycle's pop, so a pop never frees a slot for a same-cycle push.
  assign w_push  = w_push_req & ~w_full;

  assign w_head      = r_mem[r_rd_ptr[FIFO_DEPTH_LOG2-1:0]];
  assign w_head_flag = w_head[5*BYTE_WIDTH +: 3];

  always_ff @(posedge top_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= w_desc;
    end
  end

  always_ff @(posedge top_clk or negedge top_reset_n) begin
    if (!top_reset_n) begin
      r_last_d   <= 1'b0;
      r_overflow <= 1'b0;
      r_bad_flag <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_last_d <= in_flag_last;
      if (w_push_req && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_is_bad) begin
        r_bad_flag <= 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  assign w_valid = (r_state == S_B1) || (r_state == S_RUN) ||
                   (r_state == S_B4) || (r_state == S_B5);
  assign w_hs    = w_valid & out_ready;

  always_ff @(posedge top_clk or negedge top_reset_n) begin
    if (!top_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_byte     = '0;
    w_done     = 1'b0;
    w_idx_inc  = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = (w_head_flag != 3'd0) ? S_B1 : S_FIN;
        end
      end
      S_B1: begin
        case (r_idx)
          2'd0:    w_byte = r_b1;
          2'd1:    w_byte = r_b2;
          default: w_byte = r_b3;
        endcase
        if (w_hs) begin
          if (r_flag <= 3'd3) begin
            if (({1'b0, r_idx} + 3'd1) == r_flag) begin
              w_next = S_FIN;
            end else begin
              w_idx_inc = 1'b1;
            end
          end else begin
            w_cnt_load = 1'b1;
            if (r_b3 == '0) begin
              w_next = (r_flag >= 3'd6) ? S_B4 : S_FIN;
            end else begin
              w_next = S_RUN;
            end
          end
        end
      end
      S_RUN: begin
        w_byte = r_b2;
        if (w_hs) begin
          w_cnt_dec = 1'b1;
          if (r_cnt == BYTE_ONE) begin
            w_next = (r_flag >= 3'd6) ? S_B4 : S_FIN;
          end
        end
      end
      S_B4: begin
        w_byte = r_b4;
        if (w_hs) begin
          w_next = (r_flag == 3'd7) ? S_B5 : S_FIN;
        end
      end
      S_B5: begin
        w_byte = r_b5;
        if (w_hs) begin
          w_next = S_FIN;
        end
      end
      S_FIN: begin
        w_done = r_last;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge top_clk or negedge top_reset_n) begin
    if (!top_reset_n) begin
      r_b1   <= '0;
      r_b2   <= '0;
      r_b3   <= '0;
      r_b4   <= '0;
      r_b5   <= '0;
      r_flag <= 3'd0;
      r_last <= 1'b0;
      r_idx  <= 2'd0;
      r_cnt  <= '0;
    end else begin
      if (w_pop) begin
        r_b1   <= w_head[0*BYTE_WIDTH +: BYTE_WIDTH];
        r_b2   <= w_head[1*BYTE_WIDTH +: BYTE_WIDTH];
        r_b3   <= w_head[2*BYTE_WIDTH +: BYTE_WIDTH];
        r_b4   <= w_head[3*BYTE_WIDTH +: BYTE_WIDTH];
        r_b5   <= w_head[4*BYTE_WIDTH +: BYTE_WIDTH];
        r_flag <= w_head_flag;
        r_last <= w_head[5*BYTE_WIDTH + 3];
        r_idx  <= 2'd0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_cnt_load) begin
        r_cnt <= r_b3;
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - BYTE_ONE;
      end
    end
  end

`ifdef BITSTREAM_UNPACK_COUNT_EN
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = 1;

  logic [COUNT_WIDTH-1:0] r_frame_cnt;
  logic [COUNT_WIDTH-1:0] r_frame_held;

  always_ff @(posedge top_clk or negedge top_reset_n) begin
    if (!top_reset_n) begin
      r_frame_cnt  <= '0;
      r_frame_held <= '0;
    end else if (w_done) begin
      r_frame_held <= r_frame_cnt;
      r_frame_cnt  <= '0;
    end else if (w_hs && !(&r_frame_cnt)) begin
      r_frame_cnt <= r_frame_cnt + COUNT_ONE;
    end
  end

  // The pulse cycle shows the live count; afterwards the held copy stands in.
  assign out_frame_bytes = w_done ? r_frame_cnt : r_frame_held;
`endif

  assign out_byte       = w_byte;
  assign out_valid      = w_valid;
  assign out_frame_done = w_done;
  assign out_overflow   = r_overflow;
  assign out_bad_flag   = r_bad_flag;
  assign out_fifo_empty = w_empty;

endmodule
